// File: rtl/cosmos_pkg.sv
// Shared types and default sizing for the constraint result path.
package cosmos_pkg;

  localparam int unsigned DEF_N_SPLIT = 16;
  localparam int unsigned DEF_ID_W    = 32;
  localparam int unsigned DEF_CNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } coll_state_e;

  typedef struct packed {
    logic [DEF_ID_W-1:0]    id;
    logic                   sat;
    logic [DEF_N_SPLIT-1:0] fail_mask;
  } verdict_t;

endpackage

// File: rtl/constraint_collector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/constraint_collector.sv
// Registers one split-checker result per beat, streams verdicts and runs the
// search-session FSM that stops on TARGET satisfying candidates or the last one.
module constraint_collector
  import cosmos_pkg::*;
#(
  parameter int unsigned N_SPLIT = DEF_N_SPLIT,
  parameter int unsigned ID_W    = DEF_ID_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TARGET  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ID_W-1:0]    in_id,
  input  logic               in_last,
  input  logic [N_SPLIT-1:0] in_split,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    out_id,
  output logic               out_sat,
  output logic [N_SPLIT-1:0] out_fail_mask,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [ID_W-1:0]    first_id,
  output logic [CNT_W-1:0]   cnt_checked,
  output logic [CNT_W-1:0]   cnt_sat
);

  localparam logic [CNT_W:0] TARGET_X = (CNT_W+1)'(TARGET);
  localparam logic [CNT_W:0] ONE_X    = (CNT_W+1)'(1);

  coll_state_e state, state_nxt;
  logic        accept;
  logic        beat_sat;
  logic        start_ok;
  logic        hit_target;
  logic        stop;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign beat_sat = &in_split;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  // Compare one bit wider so a saturated cnt_sat cannot alias onto TARGET.
  assign hit_target = beat_sat && (({1'b0, cnt_sat} + ONE_X) == TARGET_X);
  assign stop       = accept && (in_last || hit_target);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop) state_nxt = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_id        <= '0;
      out_sat       <= 1'b0;
      out_fail_mask <= '0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_id        <= in_id;
      out_sat       <= beat_sat;
      out_fail_mask <= ~in_split;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found    <= 1'b0;
      first_id <= '0;
    end else if (start_ok) begin
      found    <= 1'b0;
      first_id <= '0;
    end else if (accept && beat_sat && !found) begin
      found    <= 1'b1;
      first_id <= in_id;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_checked (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (accept),
    .q     (cnt_checked)
  );

  sat_counter #(.W(CNT_W)) u_cnt_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (accept && beat_sat),
    .q     (cnt_sat)
  );

endmodule

// File: tb/tb_constraint_collector.sv
// Self-checking bench for constraint_collector: directed scenarios plus a
// randomized run against a transaction-level session model.
module tb_constraint_collector;

  localparam int unsigned TARGET_A = 2;
  localparam int unsigned CMAX_A   = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid, in_last, out_ready;
  logic [7:0] in_id;
  logic [3:0] in_split;
  logic       in_ready, out_valid, out_sat, busy, done, found;
  logic [7:0] out_id, first_id, cnt_checked, cnt_sat;
  logic [3:0] out_fail_mask;

  logic       b_start, b_in_valid, b_in_last, b_out_ready;
  logic [7:0] b_in_id;
  logic [3:0] b_in_split;
  logic       b_in_ready, b_out_valid, b_out_sat, b_busy, b_done, b_found;
  logic [7:0] b_out_id, b_first_id;
  logic [3:0] b_out_fail_mask;
  logic [1:0] b_cnt_checked, b_cnt_sat;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Session model: a pending-verdict slot plus session bookkeeping.
  bit          m_open, m_stopping, m_done, m_pend, m_sat, m_found;
  logic [7:0]  m_id, m_first;
  logic [3:0]  m_mask;
  int unsigned m_chk, m_satc;

  always #5 clk = ~clk;

  constraint_collector #(.N_SPLIT(4), .ID_W(8), .CNT_W(8), .TARGET(TARGET_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_last(in_last), .in_split(in_split), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_sat(out_sat), .out_fail_mask(out_fail_mask),
    .busy(busy), .done(done), .found(found), .first_id(first_id),
    .cnt_checked(cnt_checked), .cnt_sat(cnt_sat)
  );

  constraint_collector #(.N_SPLIT(4), .ID_W(8), .CNT_W(2), .TARGET(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_id(b_in_id), .in_last(b_in_last), .in_split(b_in_split), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_id(b_out_id), .out_sat(b_out_sat),
    .out_fail_mask(b_out_fail_mask), .busy(b_busy), .done(b_done), .found(b_found),
    .first_id(b_first_id), .cnt_checked(b_cnt_checked), .cnt_sat(b_cnt_sat)
  );

  task automatic model_reset();
    m_open = 0; m_stopping = 0; m_done = 0; m_pend = 0; m_sat = 0; m_found = 0;
    m_id = '0; m_first = '0; m_mask = '0; m_chk = 0; m_satc = 0;
  endtask

  function automatic bit model_in_ready();
    return m_open && (!m_pend || out_ready);
  endfunction

  // Advance the model with the inputs present before the edge, then the clock.
  task automatic tick();
    bit acc, was_pend, sat_beat, reach;
    acc      = in_valid && model_in_ready();
    was_pend = m_pend;
    sat_beat = (in_split == 4'hF);
    if (start && !m_open && !m_stopping) begin
      m_open = 1; m_done = 0; m_chk = 0; m_satc = 0; m_found = 0; m_first = '0;
    end
    if (m_stopping && (!was_pend || out_ready)) begin
      m_stopping = 0; m_done = 1;
    end
    if (acc) begin
      m_pend = 1; m_id = in_id; m_sat = sat_beat; m_mask = ~in_split;
      if (m_chk < CMAX_A) m_chk++;
      reach = 0;
      if (sat_beat) begin
        reach = (m_satc + 1 == TARGET_A);
        if (m_satc < CMAX_A) m_satc++;
        if (!m_found) begin m_found = 1; m_first = in_id; end
      end
      if (in_last || reach) begin m_open = 0; m_stopping = 1; end
    end else if (out_ready) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; in_valid = 0; in_last = 0; out_ready = 1; in_id = '0; in_split = '0;
    b_start = 0; b_in_valid = 0; b_in_last = 0; b_out_ready = 1; b_in_id = '0; b_in_split = '0;
    model_reset();
    #2;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if ({out_valid, out_sat, busy, done, found} !== 5'b0) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {out_valid, out_sat, busy, done, found}); end
    vectors++; if ({out_id, first_id, cnt_checked, cnt_sat, out_fail_mask} !== 36'h0) begin miscompares++; $display("FAIL reset_regs got %h want 0", {out_id, first_id, cnt_checked, cnt_sat, out_fail_mask}); end
    @(posedge clk); #1;
    rst_n = 1;
    start = 1;
    tick();
    start = 0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL start_in_ready got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_busy got %b want 1", busy); end
  endtask

  task automatic test_target();
    logic [7:0] ids [4]  = '{8'd10, 8'd11, 8'd12, 8'd13};
    logic [3:0] spl [4]  = '{4'hF, 4'h6, 4'hF, 4'hF};
    logic       xsat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_id = ids[i]; in_split = spl[i]; in_last = 0;
      #1;
      vectors++; if (in_ready !== (i < 3)) begin miscompares++; $display("FAIL target_in_ready beat %0d got %b want %b", i, in_ready, (i < 3)); end
      tick();
      if (i < 3) begin
        vectors++; if (out_id !== ids[i] || out_sat !== xsat[i]) begin miscompares++; $display("FAIL target_verdict beat %0d got id %0d sat %b want id %0d sat %b", i, out_id, out_sat, ids[i], xsat[i]); end
      end
      if (i == 1) begin
        vectors++; if (out_fail_mask !== 4'h9) begin miscompares++; $display("FAIL target_mask got %h want 9", out_fail_mask); end
      end
    end
    in_valid = 0;
    vectors++; if (first_id !== 8'd10) begin miscompares++; $display("FAIL target_first_id got %0d want 10", first_id); end
    vectors++; if (cnt_sat !== 8'd2 || cnt_checked !== 8'd3) begin miscompares++; $display("FAIL target_counts got sat %0d chk %0d want 2 3", cnt_sat, cnt_checked); end
    vectors++; if (out_id !== 8'd12 || done !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL target_end got id %0d done %b valid %b want 12 1 0", out_id, done, out_valid); end
  endtask

  task automatic test_backpressure();
    start = 1; tick(); start = 0;
    out_ready = 0; in_valid = 1; in_id = 8'd20; in_split = 4'h3; in_last = 0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
    tick();
    in_id = 8'd21; in_split = 4'h5;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready cycle %0d got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1 || out_id !== 8'd20 || out_fail_mask !== 4'hC || out_sat !== 1'b0) begin miscompares++; $display("FAIL bp_hold_out cycle %0d got v%b id %0d m %h s %b want v1 id 20 m c s 0", i, out_valid, out_id, out_fail_mask, out_sat); end
      tick();
    end
    out_ready = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_id !== 8'd21 || cnt_checked !== 8'd2) begin miscompares++; $display("FAIL bp_reload got v%b id %0d chk %0d want v1 id 21 chk 2", out_valid, out_id, cnt_checked); end
    in_id = 8'd22; in_split = 4'h0; in_last = 1;
    tick();
    in_valid = 0; in_last = 0;
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done got %b want 1", done); end
  endtask

  task automatic test_last();
    start = 1; tick(); start = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_id = 8'(30 + i); in_split = 4'($urandom_range(0, 14)); in_last = (i == 2);
      tick();
    end
    in_valid = 0; in_last = 0;
    #1;
    vectors++; if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL last_drain got busy %b done %b rdy %b want 1 0 0", busy, done, in_ready); end
    tick();
    vectors++; if (done !== 1'b1 || found !== 1'b0 || cnt_checked !== 8'd3 || cnt_sat !== 8'd0) begin miscompares++; $display("FAIL last_done got done %b found %b chk %0d sat %0d want 1 0 3 0", done, found, cnt_checked, cnt_sat); end
    start = 1; tick(); start = 0;
    vectors++; if (cnt_checked !== 8'd0 || cnt_sat !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL last_restart got chk %0d sat %0d busy %b done %b want 0 0 1 0", cnt_checked, cnt_sat, busy, done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 15) == 0);
      in_id     = 8'($urandom);
      in_split  = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      #1;
      vectors++; if (in_ready !== model_in_ready()) begin miscompares++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", i, in_ready, model_in_ready()); end
      tick();
      vectors++; if (out_valid !== m_pend) begin miscompares++; $display("FAIL rnd_out_valid cycle %0d got %b want %b", i, out_valid, m_pend); end
      vectors++; if (out_id !== m_id || out_sat !== m_sat || out_fail_mask !== m_mask) begin miscompares++; $display("FAIL rnd_verdict cycle %0d got %0d/%b/%h want %0d/%b/%h", i, out_id, out_sat, out_fail_mask, m_id, m_sat, m_mask); end
      vectors++; if (busy !== (m_open || m_stopping) || done !== m_done) begin miscompares++; $display("FAIL rnd_state cycle %0d got busy %b done %b want %b %b", i, busy, done, (m_open || m_stopping), m_done); end
      vectors++; if (found !== m_found || first_id !== m_first) begin miscompares++; $display("FAIL rnd_found cycle %0d got %b/%0d want %b/%0d", i, found, first_id, m_found, m_first); end
      vectors++; if (cnt_checked !== 8'(m_chk) || cnt_sat !== 8'(m_satc)) begin miscompares++; $display("FAIL rnd_counts cycle %0d got %0d/%0d want %0d/%0d", i, cnt_checked, cnt_sat, m_chk, m_satc); end
    end
    start = 0; in_valid = 0; in_last = 0; out_ready = 1;
  endtask

  task automatic test_saturation();
    int unsigned want;
    b_start = 1; tick(); b_start = 0;
    b_out_ready = 1; b_in_valid = 1; b_in_split = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      b_in_id = 8'(50 + k);
      tick();
      want = (k < 3) ? k : 3;
      vectors++; if (b_cnt_checked !== 2'(want)) begin miscompares++; $display("FAIL sat_cnt beat %0d got %0d want %0d", k, b_cnt_checked, want); end
    end
    b_in_valid = 0;
    vectors++; if (b_busy !== 1'b1 || b_cnt_sat !== 2'd0 || b_found !== 1'b0) begin miscompares++; $display("FAIL sat_state got busy %b sat %0d found %b want 1 0 0", b_busy, b_cnt_sat, b_found); end
  endtask

  task automatic test_async_reset();
    rst_n = 0; #1; rst_n = 1;
    model_reset();
    start = 1; tick(); start = 0;
    out_ready = 0; in_valid = 1; in_last = 1; in_id = 8'd40; in_split = 4'hF;
    tick();
    in_valid = 0; in_last = 0;
    tick();
    vectors++; if (busy !== 1'b1 || out_valid !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL arst_pre got busy %b valid %b done %b want 1 1 0", busy, out_valid, done); end
    #3;
    rst_n = 0;
    #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_now got valid %b busy %b rdy %b want 0 0 0", out_valid, busy, in_ready); end
    vectors++; if (out_id !== 8'd0 || cnt_checked !== 8'd0 || found !== 1'b0) begin miscompares++; $display("FAIL arst_regs got id %0d chk %0d found %b want 0 0 0", out_id, cnt_checked, found); end
    #2;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_target();
    test_backpressure();
    test_last();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
